// File: rtl/cpu_pkg.sv
// Shared constants and types for the IF/ID boundary register.
// Holds the NOP encoding presented on empty slots, the PC step and the state encoding.
// Ports: none (package only).
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// Purpose: one pipeline slot holding a PC/instruction pair plus a valid bit.
// Latency: load takes effect on the next rising clk edge.
// Backpressure: none inside; the owner decides when to load or clear.
// Ports: clk/rst (sync, active-high); ld loads d_* and sets valid;
//        clr drops valid but keeps the data; q_* are the registered contents.
module pipe_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_instr,
  output logic              q_vld,
  output logic [DATA_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld   <= 1'b0;
      q_pc    <= '0;
      q_instr <= '0;
    end else if (ld) begin
      q_vld   <= 1'b1;
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end else if (clr) begin
      // Data is kept so id_pc holds its last value while invalid.
      q_vld   <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// Purpose: IF/ID boundary register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from fetch accept to id_valid.
// Backpressure: if_ready drops only when both entries are held; never combinational on id_ready.
// Ports: if_valid/if_ready/if_pc/if_instr from fetch; id_valid/id_ready/id_pc/
//        id_pc_plus4/id_instr to decode; flush squashes held and offered entries;
//        stall_cnt saturates counting cycles with id_valid && !id_ready.
module if_id_skid_reg
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic [DATA_W-1:0] id_instr,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e state_q, state_d;

  logic              accept, consume;
  logic              main_ld, main_clr, main_from_skid;
  logic              skid_ld, skid_clr;
  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_pc, main_instr;
  logic [DATA_W-1:0] skid_pc, skid_instr;
  logic [DATA_W-1:0] main_d_pc, main_d_instr;

  assign if_ready = !rst && (state_q != SKID);
  assign accept   = if_valid && if_ready;
  assign consume  = main_vld && id_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // A same-cycle consume has already been taken by decode; only the
      // offered and held entries are dropped.
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_ld = 1'b1;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_ld = 1'b1;
          end else if (consume) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end else if (accept) begin
            state_d = SKID;
            skid_ld = 1'b1;
          end
        end
        SKID: begin
          // The skid slot is always valid here; the guard keeps slot and
          // state consistent should they ever disagree.
          if (consume && skid_vld) begin
            state_d        = FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : if_pc;
  assign main_d_instr = main_from_skid ? skid_instr : if_instr;

  pipe_entry #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .ld      (main_ld),
    .clr     (main_clr),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .q_vld   (main_vld),
    .q_pc    (main_pc),
    .q_instr (main_instr)
  );

  pipe_entry #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .ld      (skid_ld),
    .clr     (skid_clr),
    .d_pc    (if_pc),
    .d_instr (if_instr),
    .q_vld   (skid_vld),
    .q_pc    (skid_pc),
    .q_instr (skid_instr)
  );

  assign id_valid    = main_vld;
  assign id_pc       = main_pc;
  assign id_pc_plus4 = main_pc + DATA_W'(PC_INC);
  assign id_instr    = main_vld ? main_instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, if_valid, if_ready, flush, id_valid, id_ready;
  logic [DW-1:0] if_pc, if_instr, id_pc, id_pc_plus4, id_instr;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  if_id_skid_reg #(.DATA_W(DW), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            known = 1'b0;
  logic [31:0]   last_pc = '0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update the model.
  task automatic cyc(input bit r, input bit v, input bit fl, input bit rdy,
                     input logic [31:0] pc, input logic [31:0] ins);
    bit exp_rdy = 1'b0;
    bit exp_vld = 1'b0;
    bit acc     = 1'b0;
    bit con     = 1'b0;
    rst = r; if_valid = v; flush = fl; id_ready = rdy; if_pc = pc; if_instr = ins;
    #1;
    exp_rdy = !r && (sb.size() < 2);
    chk("if_ready", {63'd0, if_ready}, {63'd0, exp_rdy});
    if (known) begin
      exp_vld = (sb.size() > 0);
      chk("id_valid",    {63'd0, id_valid}, {63'd0, exp_vld});
      chk("id_pc",       {32'd0, id_pc}, {32'd0, last_pc});
      chk("id_pc_plus4", {32'd0, id_pc_plus4}, {32'd0, last_pc + 32'd4});
      chk("id_instr",    {32'd0, id_instr}, {32'd0, (exp_vld ? sb[0].instr : NOP)});
      chk("stall_cnt",   {60'd0, stall_cnt}, {60'd0, m_cnt});
    end
    if (r) begin
      sb.delete();
      m_cnt   = '0;
      last_pc = '0;
      known   = 1'b1;
    end else if (known) begin
      con = exp_vld && rdy;
      acc = v && exp_rdy;
      if (exp_vld && !rdy && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
      if (con) void'(sb.pop_front());
      if (fl) sb.delete();
      else if (acc) sb.push_back({pc, ins});
      if (sb.size() > 0) last_pc = sb[0].pc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with fetch already offering.
    cyc(1, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0, 32'h0);

    // Streaming.
    cyc(0, 1, 0, 1, 32'h0, 32'h2008_0005);
    cyc(0, 1, 0, 1, 32'h4, 32'h2009_0003);
    cyc(0, 1, 0, 1, 32'h8, 32'h0109_5020);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);

    // Back-pressure into SKID, then release.
    cyc(0, 1, 0, 0, 32'h0, 32'hAAAA_0000);
    cyc(0, 1, 0, 0, 32'h4, 32'hBBBB_0004);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);

    // Flush while in SKID with a simultaneous offer of pc 0x10.
    cyc(0, 1, 0, 0, 32'h100, 32'h1111_0100);
    cyc(0, 1, 0, 0, 32'h104, 32'h1111_0104);
    cyc(0, 1, 1, 0, 32'h10,  32'hDEAD_0010);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);

    // Flush in FULL with a same-cycle consume and an accept that must be dropped.
    cyc(0, 1, 0, 0, 32'h200, 32'h2222_0200);
    cyc(0, 1, 1, 1, 32'h10,  32'hDEAD_0010);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);

    // PC+4 wrap.
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 32'h3333_FFFC);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h0);

    // Counter saturation, then reset mid-stall.
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 32'h40, 32'h4444_0040);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 32'h0, 32'h0);
    chk("stall_sat", {60'd0, stall_cnt}, 64'hF);
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_cnt", {60'd0, stall_cnt}, 64'h0);
    chk("rst_vld", {63'd0, id_valid}, 64'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0);

    // Mixed random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) != 0),
          32'h1000 + 32'(i) * 32'd4,
          $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline boundary register that sits directly downstream of the Instruction_Fetch stage.
- Captures the fetched instruction and its PC, then presents them to the decode stage through a valid/ready handshake.
- A 2-entry skid buffer lets decode back-pressure without losing an instruction already fetched. A flush input squashes wrong-path instructions after a branch or jump.
- A saturating counter records decode-stall cycles for performance debug.

Parameters:
- DATA_W, 32, width of instruction and PC words.
- NOP_INSTR, 32'h0000_0000, value driven on id_instr whenever no valid entry is presented.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch stage presents a valid instruction.
- if_ready  output  1  block can accept an instruction this cycle.
- if_pc  input  DATA_W  PC of the fetched instruction (fetch PC_Out).
- if_instr  input  DATA_W  fetched instruction word.
- flush  input  1  squash all held entries and any entry offered this cycle.
- id_valid  output  1  decode-side entry valid.
- id_ready  input  1  decode consumes the entry this cycle.
- id_pc  output  DATA_W  PC of the presented instruction.
- id_pc_plus4  output  DATA_W  id_pc + 4, modulo 2^DATA_W.
- id_instr  output  DATA_W  presented instruction, or NOP_INSTR when id_valid=0.
- stall_cnt  output  CNT_W  count of cycles with id_valid=1 and id_ready=0.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values, applied on the clk edge with rst=1:
  - id_valid=0, id_pc=0, id_pc_plus4=4, id_instr=NOP_INSTR, stall_cnt=0.
  - Internal state EMPTY, skid entry invalid.
- if_ready is a combinational function of registered state: if_ready = !rst && (state != SKID). It never depends combinationally on id_ready.
- Accept = if_valid && if_ready. Consume = id_valid && id_ready.
- Outputs are registered: the main entry drives id_*. Latency from if accept to id_valid is 1 cycle.
- States and transitions (flush=0):
  - EMPTY: accept -> FULL, main <= if_*.
  - FULL with consume and accept -> FULL, main <= if_*.
  - FULL with consume and no accept -> EMPTY.
  - FULL with accept and no consume -> SKID, skid <= if_*.
  - FULL with neither -> FULL, main holds.
  - SKID with consume -> FULL, main <= skid. No accept is possible in SKID (if_ready=0).
  - SKID without consume -> hold.
- Ordering is strict FIFO; the skid entry is never presented ahead of main.
- flush=1 (highest priority after rst):
  - Next state EMPTY and id_valid=0 next cycle.
  - Any same-cycle accept is discarded; if_ready still reads as its normal value.
  - A same-cycle consume completes normally; decode owns that instruction.
- rst mid-operation overrides flush and any handshake. Held entries are lost.
- While id_valid=1 and id_ready=0, id_pc, id_pc_plus4 and id_instr are stable.
- id_instr = NOP_INSTR and id_pc holds its last value whenever id_valid=0.
- id_pc_plus4 is computed from the registered id_pc and wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- stall_cnt increments when id_valid && !id_ready. It saturates at all-ones, does not wrap, and clears only on rst.

Decomposition:
- Shared package (cpu_pkg): NOP_INSTR constant, PC increment constant (4), and the state enumeration EMPTY=2'd0, FULL=2'd1, SKID=2'd2.
- Sub-module pipe_entry: a DATA_W-pair holding register with valid and load enable, instantiated twice (main and skid). Everything else stays in the top-level block.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1 -> if_ready=0, id_valid=0, id_instr=NOP_INSTR, id_pc_plus4=4, stall_cnt=0.
- Streaming: id_ready=1, offer pc 0,4,8 with instr 0x20080005, 0x20090003, 0x01095020 -> each appears 1 cycle later in order, if_ready stays 1, stall_cnt=0.
- Back-pressure: id_ready=0 while offering pc 0 then 4 -> state SKID, if_ready=0, id_pc=0 held. Release id_ready -> id_pc=4 the next cycle, if_ready=1, stall_cnt equals the number of stalled cycles.
- Flush with entries in SKID and a simultaneous if_valid (pc 0x10) -> next cycle id_valid=0, id_instr=NOP_INSTR, pc 0x10 never appears.
- Wrap: accept pc 32'hFFFF_FFFC -> id_pc_plus4=32'h0000_0000.
- Saturation (CNT_W=4): hold id_ready=0 with id_valid=1 for 20 cycles -> stall_cnt=4'hF. Assert rst mid-stall -> stall_cnt=0 and id_valid=0 next cycle.
